mprjram_arbiter: RTL and testbench
==================================

# mprjram_arbiter

Two-requester arbiter and access sequencer for the user-project BRAM (mprjram, 0x3800_0000 window) inside the user project wrapper. It shares one single-port BRAM between the management-core Wishbone slave port and a logic-analyzer (LA) driven requester. Each access is delayed by a programmable number of wait states to emulate slow memory. Firmware runs code and data (e.g. matmul) from this BRAM while the LA side can read or inject results.

## Interface
- ADDR_W, 10: BRAM word-address width (4 KiB).
- DELAYS, 10: wait-state cycles inserted before every BRAM access; 0 allowed.
- wb_clk_i  in  1  single clock for everything.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address; decoded only when [31:24]==8'h38; word index = [ADDR_W+1:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle ack.
- wbs_dat_o  out  32  read data, valid with ack.
- la_req_i, la_we_i  in  1 each  LA request (level) and write select.
- la_adr_i  in  ADDR_W  LA word address.
- la_dat_i  in  32  LA write data (full word).
- la_ack_o  out  1  one-cycle completion.
- la_dat_o  out  32  LA read data, valid with la_ack_o.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  4  BRAM byte write enables.
- bram_adr_o  out  ADDR_W  BRAM word address.
- bram_wdat_o  out  32  BRAM write data.
- bram_rdat_i  in  32  BRAM read data, one-cycle latency after bram_en_o.

## Operation
- FSM: IDLE -> WAIT -> ACCESS -> RESP -> IDLE; WAIT skipped when DELAYS==0.
- IDLE: WB request = cyc&stb&addr-hit; LA request = la_req_i. On any request, latch grant, we, sel (LA: 4'hF), word address, write data; load counter with DELAYS.
- Arbitration: round-robin on a 1-bit last-served flag; sole requester always wins; on simultaneous requests, the one not last served wins. Reset value of the flag = LA, so WB wins the first tie.
- WAIT: counter decrements each cycle; leave when it reaches 1 (exactly DELAYS cycles in WAIT).
- ACCESS: bram_en_o=1, bram_we_o = latched sel if write else 0, address and data from latches.
- RESP: capture bram_rdat_i to winner's data output. Pulse winner's ack. WB ack is gated by wbs_cyc_i still high; LA ack is unconditional. Update the last-served flag. Then go to IDLE.
- Writes return data output = 0. Non-hit WB addresses are ignored, never acked.
- A dropped cyc/stb or la_req_i after grant does not abort; the BRAM access (including a write) completes.
- Loser's request stays pending; it is re-arbitrated in the next IDLE.

## Timing
- Request visible in IDLE at cycle 0 -> bram_en_o at cycle DELAYS+1 -> ack at cycle DELAYS+2.
- Minimum spacing between two grants: DELAYS+3 cycles.
- Wishbone classic: the master deasserts stb the cycle after ack. A stb still high in IDLE is a new transaction.
- Reset values: state IDLE, counter 0, all outputs 0 (acks, bram_en_o, bram_we_o, addresses, data).
- Reset asserted mid-operation: the next cycle is IDLE with all outputs 0. No BRAM write is issued in or after the reset cycle. A pending ack is dropped.
- Outputs driven from registers or state decode only. There is no combinational path from any request input to bram_* or ack.

## Structure
- Shared package mprjram_pkg holds:
  - state enum (IDLE, WAIT, ACCESS, RESP);
  - grant encoding (GNT_WB, GNT_LA);
  - MPRJRAM_BASE = 8'h38.
- Sub-module rr_arb2: 2-way round-robin; inputs req[1:0] and update strobe, output one-hot grant. Instantiated once.

## Test plan
- WB read, DELAYS=10: BRAM preloaded word 5 = 32'h0000_003E; read 0x3800_0014 -> ack exactly 12 cycles after stb, wbs_dat_o=32'h0000_003E, single ack pulse.
- WB byte write: sel=4'b0010 to 0x3800_0000, data 32'hAABB_CCDD -> bram_we_o=4'b0010 in ACCESS cycle only. Following read returns old bytes with byte1=8'hCC.
- Simultaneous WB read word 0 and LA write word 1 (32'h0000_0044) from reset -> WB granted first. LA ack exactly DELAYS+3 cycles later. LA readback of word 1 = 32'h0000_0044.
- Continuous requests on both ports for 8 transactions -> grants strictly alternate WB, LA, WB, …
- Non-hit WB address 0x3000_0000 -> no ack, no bram_en_o, FSM stays IDLE.
- wb_rst_i asserted during WAIT of an LA write -> no bram_en_o and no la_ack_o afterward. Outputs 0 next cycle. A fresh WB request after reset completes normally.

Source files
------------

// File: rtl/mprjram_pkg.sv
// mprjram_pkg: shared definitions for the user-project BRAM arbiter.
//   - FSM state codes (IDLE, WAIT, ACCESS, RESP) and their storage type
//   - grant encoding (GNT_WB, GNT_LA)
//   - MPRJRAM_BASE: address byte [31:24] that selects the BRAM window
//   - gnt_onehot(): converts a 1-bit grant code to the arbiter's one-hot form
package mprjram_pkg;

    localparam logic [7:0] MPRJRAM_BASE = 8'h38;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam logic GNT_WB = 1'b0;
    localparam logic GNT_LA = 1'b1;

    // Bit 0 of the one-hot vector is the Wishbone requester, bit 1 is LA.
    function automatic logic [1:0] gnt_onehot(input logic gnt);
        return (gnt == GNT_LA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mprjram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a single last-served flag.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req[1:0]    request vector (bit 0 = WB, bit 1 = LA)
//   update      when high, the current grant is recorded as last served
//   gnt[1:0]    one-hot grant (all zero when nothing is requested)
// A sole requester always wins; on a tie the requester not served last wins.
// The flag resets to LA so Wishbone wins the first tie.
module rr_arb2
    import mprjram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == GNT_LA) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_LA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: shares one single-port BRAM between the management-core
// Wishbone slave port and an LA-driven requester, inserting DELAYS wait
// states before every access.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_*                  Wishbone classic slave (byte address, 4 byte enables)
//   la_*                   LA requester (level request, word address, full word)
//   bram_*                 BRAM port, read data one cycle after bram_en_o
//   dbg_state_o            current FSM state code
//
// Handshake: a Wishbone request is cyc&stb with an address in the 0x38 window,
// held until wbs_ack_o; the master drops stb the cycle after ack, so a stb still
// high when the FSM is back in IDLE is a new transaction. An LA request is
// la_req_i held high until la_ack_o. Each ack is a single-cycle pulse and the
// matching data output is valid in that cycle. Once granted, a transaction
// always runs to completion even if its request drops.
module mprjram_arbiter
    import mprjram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DELAYS = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_adr_i,
    input  logic [31:0]       la_dat_i,
    output logic              la_ack_o,
    output logic [31:0]       la_dat_o,
    output logic              bram_en_o,
    output logic [3:0]        bram_we_o,
    output logic [ADDR_W-1:0] bram_adr_o,
    output logic [31:0]       bram_wdat_o,
    input  logic [31:0]       bram_rdat_i,
    output logic [1:0]        dbg_state_o
);

    // Wide enough to hold DELAYS, and at least one bit when DELAYS is 0.
    localparam int   CNT_W     = $clog2(DELAYS + 2);
    localparam logic SKIP_WAIT = (DELAYS == 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [31:0]         wdat_q, wdat_d;
    logic                en_q, en_d;
    logic [3:0]          bwe_q, bwe_d;
    logic                wack_q, wack_d;
    logic                lack_q, lack_d;
    logic [31:0]         wrd_q, wrd_d;
    logic [31:0]         lrd_q, lrd_d;

    logic                wb_hit;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                arb_upd;
    logic [31:0]         rsp_dat;
    logic                unused_adr;

    assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    assign wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == MPRJRAM_BASE);

    // Outside IDLE the arbiter sees only the latched winner, so the update
    // strobe in RESP records exactly the requester that was served.
    assign arb_req = (state_q == ST_IDLE) ? {la_req_i, wb_hit} : gnt_onehot(gnt_q);
    assign arb_upd = (state_q == ST_RESP);

    rr_arb2 u_rr_arb2 (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .req    (arb_req),
        .update (arb_upd),
        .gnt    (arb_gnt)
    );

    // Writes report zero; reads report the word the BRAM returns in RESP.
    assign rsp_dat = we_q ? 32'h0 : bram_rdat_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        wrd_d   = wrd_q;
        lrd_d   = lrd_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    gnt_d = arb_gnt[1];
                    if (arb_gnt[1]) begin
                        we_d   = la_we_i;
                        sel_d  = 4'hF;
                        adr_d  = la_adr_i;
                        wdat_d = la_dat_i;
                    end else begin
                        we_d   = wbs_we_i;
                        sel_d  = wbs_sel_i;
                        adr_d  = wbs_adr_i[ADDR_W+1:2];
                        wdat_d = wbs_dat_i;
                    end
                    cnt_d   = CNT_W'(DELAYS);
                    state_d = SKIP_WAIT ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Entered with DELAYS loaded; leaving at 1 gives DELAYS cycles.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            default: begin
                if (gnt_q == GNT_WB) begin
                    wrd_d = rsp_dat;
                end else begin
                    lrd_d = rsp_dat;
                end
                state_d = ST_IDLE;
            end
        endcase

        // Output strobes are registered one cycle ahead of the state they
        // belong to, so no request input reaches an output combinationally.
        en_d   = (state_d == ST_ACCESS);
        bwe_d  = ((state_d == ST_ACCESS) && we_d) ? sel_d : 4'h0;
        wack_d = (state_d == ST_RESP) && (gnt_d == GNT_WB) && wbs_cyc_i;
        lack_d = (state_d == ST_RESP) && (gnt_d == GNT_LA);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= GNT_WB;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            wdat_q  <= 32'h0;
            en_q    <= 1'b0;
            bwe_q   <= 4'h0;
            wack_q  <= 1'b0;
            lack_q  <= 1'b0;
            wrd_q   <= 32'h0;
            lrd_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            en_q    <= en_d;
            bwe_q   <= bwe_d;
            wack_q  <= wack_d;
            lack_q  <= lack_d;
            wrd_q   <= wrd_d;
            lrd_q   <= lrd_d;
        end
    end

    // Reset masks the strobes within the reset cycle itself, so a BRAM write
    // or ack that was already registered never reaches the BRAM or a master.
    assign bram_en_o   = en_q & ~wb_rst_i;
    assign bram_we_o   = bwe_q & {4{~wb_rst_i}};
    assign bram_adr_o  = adr_q;
    assign bram_wdat_o = wdat_q;
    assign wbs_ack_o   = wack_q & ~wb_rst_i;
    assign la_ack_o    = lack_q & ~wb_rst_i;

    // In RESP the winner sees the live BRAM word; afterwards the captured copy.
    assign wbs_dat_o = ((state_q == ST_RESP) && (gnt_q == GNT_WB)) ? rsp_dat : wrd_q;
    assign la_dat_o  = ((state_q == ST_RESP) && (gnt_q == GNT_LA)) ? rsp_dat : lrd_q;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mprjram_arbiter.sv
// tb_mprjram_arbiter: randomized and directed traffic on both ports against a
// transaction-level model (round-robin slot schedule plus a reference memory).
module tb_mprjram_arbiter;
  import mprjram_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DELAYS = 10;
  localparam int SLOT   = DELAYS + 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } txn_t;

  logic              clk;
  logic              wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              la_req_i, la_we_i;
  logic [ADDR_W-1:0] la_adr_i;
  logic [31:0]       la_dat_i;
  logic              la_ack_o;
  logic [31:0]       la_dat_o;
  logic              bram_en_o;
  logic [3:0]        bram_we_o;
  logic [ADDR_W-1:0] bram_adr_o;
  logic [31:0]       bram_wdat_o;
  logic [31:0]       bram_rdat_i;
  logic [1:0]        dbg_state_o;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mprjram_arbiter #(.ADDR_W(ADDR_W), .DELAYS(DELAYS)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .la_req_i    (la_req_i),
    .la_we_i     (la_we_i),
    .la_adr_i    (la_adr_i),
    .la_dat_i    (la_dat_i),
    .la_ack_o    (la_ack_o),
    .la_dat_o    (la_dat_o),
    .bram_en_o   (bram_en_o),
    .bram_we_o   (bram_we_o),
    .bram_adr_o  (bram_adr_o),
    .bram_wdat_o (bram_wdat_o),
    .bram_rdat_i (bram_rdat_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- BRAM environment and port monitor ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'h0000_003E;
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  logic [31:0] bram [0:DEPTH-1];
  logic        preload_go;
  int          en_cnt;
  int          we_cnt;
  logic [3:0]  last_we;

  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
    end else if (bram_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we_o[b]) bram[bram_adr_o][8*b +: 8] <= bram_wdat_o[8*b +: 8];
      end
      bram_rdat_i <= bram[bram_adr_o];
    end
  end

  always @(posedge clk) begin
    if (bram_en_o) begin
      en_cnt = en_cnt + 1;
      if (bram_we_o != 4'h0) begin
        we_cnt  = we_cnt + 1;
        last_we = bram_we_o;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          model_last;          // 1: LA was served last
  logic [31:0] exp_q[$];
  bit          exp_port_q[$];
  int          exp_cyc_q[$];
  txn_t        wb_q[$];
  txn_t        la_q[$];
  int          n_total;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_apply(input txn_t t);
    if (t.we) begin
      for (int b = 0; b < 4; b++) begin
        if (t.sel[b]) ref_mem[t.adr][8*b +: 8] = t.dat[8*b +: 8];
      end
      return 32'h0;
    end
    return ref_mem[t.adr];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_wb(input txn_t t);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = t.we;
    wbs_sel_i = t.sel;
    wbs_adr_i = {MPRJRAM_BASE, 12'h000, t.adr, 2'b00};
    wbs_dat_i = t.dat;
  endtask

  task automatic idle_wb();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
  endtask

  task automatic drive_la(input txn_t t);
    la_req_i = 1'b1;
    la_we_i  = t.we;
    la_adr_i = t.adr;
    la_dat_i = t.dat;
  endtask

  task automatic idle_la();
    la_req_i = 1'b0;
    la_we_i  = 1'b0;
    la_adr_i = '0;
    la_dat_i = 32'h0;
  endtask

  function automatic txn_t mk(input logic we, input logic [3:0] sel,
                              input int adr, input logic [31:0] dat);
    txn_t t;
    t.we  = we;
    t.sel = sel;
    t.adr = ADDR_W'(adr);
    t.dat = dat;
    return t;
  endfunction

  task automatic check_ack(input bit port, input int k, input logic [31:0] dat);
    bit          ep;
    int          ec;
    logic [31:0] ed;
    if (exp_port_q.size() == 0) begin
      check("spurious_ack", 32'(port) + 32'd1, 32'd0);
    end else begin
      ep = exp_port_q.pop_front();
      ec = exp_cyc_q.pop_front();
      ed = exp_q.pop_front();
      check("ack_port", 32'(ep), 32'(port));
      check("ack_cycle", 32'(k), 32'(ec));
      check(port ? "la_data" : "wb_data", dat, ed);
    end
  endtask

  // Runs every queued transaction. Each port presents its next transaction as
  // soon as its previous one is acked, so the model is a fixed slot schedule:
  // one grant every DELAYS+3 cycles, winner picked by the round-robin rule.
  task automatic run_traffic();
    int nw, nl, wi, li, slot, k, budget, en0;
    bit pick;
    nw = wb_q.size();
    nl = la_q.size();
    wi = 0; li = 0; slot = 0;
    while (wi < nw || li < nl) begin
      if (wi < nw && li < nl) pick = model_last ? 1'b0 : 1'b1;
      else                    pick = (li < nl);
      exp_port_q.push_back(pick);
      exp_cyc_q.push_back(slot * SLOT + DELAYS + 2);
      exp_q.push_back(model_apply(pick ? la_q[li] : wb_q[wi]));
      if (pick) li++; else wi++;
      model_last = pick;
      slot++;
    end
    budget = (nw + nl) * SLOT + 20;
    en0 = en_cnt;
    wi = 0; li = 0; k = 0;
    @(negedge clk);
    if (nw > 0) drive_wb(wb_q[0]);
    if (nl > 0) drive_la(la_q[0]);
    while (exp_port_q.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (wbs_ack_o) begin
        check_ack(1'b0, k, wbs_dat_o);
        wi++;
        if (wi < nw) drive_wb(wb_q[wi]); else idle_wb();
      end
      if (la_ack_o) begin
        check_ack(1'b1, k, la_dat_o);
        li++;
        if (li < nl) drive_la(la_q[li]); else idle_la();
      end
    end
    if (exp_port_q.size() > 0) begin
      check("timeout_left", 32'(exp_port_q.size()), 32'd0);
      exp_port_q.delete();
      exp_cyc_q.delete();
      exp_q.delete();
    end
    idle_wb();
    idle_la();
    check("bram_en_count", 32'(en_cnt - en0), 32'(nw + nl));
    wb_q.delete();
    la_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   bad_cnt, en0, we0, n;
    txn_t t;
    n_total = 0; n_bad = 0;
    en_cnt = 0; we_cnt = 0; last_we = 4'h0;
    bram_rdat_i = 32'h0;
    idle_wb();
    idle_la();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_last = 1'b1;
    wb_rst_i   = 1'b1;
    preload_go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload_go = 1'b0;
    wb_rst_i   = 1'b0;
    check("reset_outs_nz", 32'(|{wbs_ack_o, wbs_dat_o, la_ack_o, la_dat_o, bram_en_o,
                                 bram_we_o, bram_adr_o, bram_wdat_o}), 32'd0);
    check("reset_state", 32'(dbg_state_o), 32'(ST_IDLE));

    // Tie from reset: WB read word 0 against LA write word 1; then LA readback.
    wb_q.push_back(mk(1'b0, 4'hF, 0, 32'h0));
    la_q.push_back(mk(1'b1, 4'hF, 1, 32'h0000_0044));
    run_traffic();
    la_q.push_back(mk(1'b0, 4'hF, 1, 32'h0));
    run_traffic();

    // Preloaded word 5 via byte address 0x3800_0014.
    wb_q.push_back(mk(1'b0, 4'hF, 5, 32'h0));
    run_traffic();

    // Byte write to word 0 lane 1, then readback.
    we0 = we_cnt;
    wb_q.push_back(mk(1'b1, 4'b0010, 0, 32'hAABB_CCDD));
    run_traffic();
    check("bytewe_cycles", 32'(we_cnt - we0), 32'd1);
    check("bytewe_mask", 32'(last_we), 32'h2);
    wb_q.push_back(mk(1'b0, 4'hF, 0, 32'h0));
    run_traffic();

    // Continuous traffic on both ports: 8 grants alternating.
    for (int i = 0; i < 4; i++) begin
      wb_q.push_back(mk(1'(i & 1), 4'hF, 8 + i, $urandom));
      la_q.push_back(mk(1'(~i & 1), 4'hF, 8 + i, $urandom));
    end
    run_traffic();

    // Address outside the window: ignored.
    en0 = en_cnt;
    bad_cnt = 0;
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = 32'h3000_0000;
    repeat (30) begin
      @(negedge clk);
      if (wbs_ack_o || bram_en_o || dbg_state_o != ST_IDLE) bad_cnt++;
    end
    idle_wb();
    check("nonhit_activity", 32'(bad_cnt), 32'd0);
    check("nonhit_en", 32'(en_cnt - en0), 32'd0);

    // Randomized rounds with overlapping addresses.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        t.we  = 1'($urandom_range(0, 1));
        t.sel = 4'($urandom_range(1, 15));
        t.adr = ADDR_W'($urandom_range(0, 15));
        t.dat = $urandom;
        wb_q.push_back(t);
      end
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        t.we  = 1'($urandom_range(0, 1));
        t.sel = 4'hF;
        t.adr = ADDR_W'($urandom_range(0, 15));
        t.dat = $urandom;
        la_q.push_back(t);
      end
      run_traffic();
    end

    // Reset during WAIT of an LA write: write never lands, ack never comes.
    @(negedge clk);
    drive_la(mk(1'b1, 4'hF, 7, 32'hDEAD_BEEF));
    repeat (3) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state_o), 32'(ST_WAIT));
    wb_rst_i = 1'b1;
    idle_la();
    @(negedge clk);
    wb_rst_i = 1'b0;
    check("rst_outs_nz", 32'(|{wbs_ack_o, wbs_dat_o, la_ack_o, la_dat_o, bram_en_o,
                               bram_we_o, bram_adr_o, bram_wdat_o}), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    model_last = 1'b1;
    en0 = en_cnt;
    bad_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (la_ack_o || bram_en_o) bad_cnt++;
    end
    check("rst_no_activity", 32'(bad_cnt), 32'd0);
    check("rst_no_en", 32'(en_cnt - en0), 32'd0);
    check("rst_word7", bram[7], ref_mem[7]);
    wb_q.push_back(mk(1'b0, 4'hF, 7, 32'h0));
    run_traffic();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
